apb_regfile_slave: RTL and testbench
====================================

APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AWIDTH  4      address width; register count = 2**AWIDTH
  DWIDTH  8      data width
  ID_VAL  8'hA5  read-only ID value at address 0 (DWIDTH bits)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  pclk      in   1       clock; all state changes on rising edge
  presetn   in   1       asynchronous active-low reset
  psel      in   1       APB select
  penable   in   1       APB enable (ACCESS phase)
  pwrite    in   1       1 = write, 0 = read
  paddr     in   AWIDTH  register address
  pwdata    in   DWIDTH  write data
  prdata    out  DWIDTH  registered read data
  proto_err out  1       sticky protocol-violation flag
  pslverr   out  1       error response; present only with APB_REGFILE_PSLVERR_EN
REQ-003 The block SHALL have one clock, pclk; reset presetn SHALL be asynchronous and active-low.
REQ-004 There SHALL be no pready; every transfer completes in one ACCESS cycle (zero wait states).

Function
REQ-005 Phase FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-006 FSM transitions at each rising edge SHALL be:
  - IDLE->SETUP on psel&!penable
  - SETUP->ACCESS on psel&penable
  - ACCESS->SETUP on psel&!penable (back-to-back)
  - ACCESS->IDLE on !psel
  - otherwise ->IDLE
REQ-007 penable=1 sampled in IDLE, or psel&!penable sampled in SETUP, SHALL set proto_err on that edge.
  - The offending cycle SHALL NOT cause any register write.
  - The FSM SHALL go to IDLE, or to SETUP for the psel&!penable case.
REQ-008 Register map:
  - addr 0: ID, read-only, reads ID_VAL
  - addr 2**AWIDTH-1: WCNT, read-only, count of completed writes
  - all others: read/write, reset 0
REQ-009 A write SHALL commit on the rising edge where FSM=SETUP and psel&penable&pwrite are sampled.
  - Write data is pwdata; address is paddr.
  - Written data SHALL be readable from the next cycle.
REQ-010 A write to ID or WCNT SHALL NOT change register contents.
REQ-011 WCNT SHALL increment by 1 on every committed write, including writes to read-only addresses, and SHALL wrap from 2**DWIDTH-1 to 0.
REQ-012 prdata SHALL load the addressed register on the rising edge where FSM is IDLE or ACCESS and psel&!penable&!pwrite are sampled.
  - prdata is therefore valid throughout the ACCESS cycle.
REQ-013 prdata SHALL hold its value after the ACCESS cycle until the next read SETUP, so a master may sample it one cycle after ACCESS.
REQ-014 On a read of WCNT in the same setup edge as a write commit, prdata SHALL return the pre-increment value.

Reset
REQ-015 With presetn low, the block SHALL immediately set:
  - FSM=IDLE
  - all RW registers, WCNT and prdata = 0
  - proto_err=0, pslverr=0
REQ-016 Reset asserted mid-transfer SHALL abort it: no write commit and no WCNT increment.
REQ-017 After presetn deasserts, the first transfer SHALL be accepted from the next psel&!penable.
REQ-018 proto_err SHALL clear only by reset.

Configuration
REQ-019 With macro APB_REGFILE_PSLVERR_EN defined:
  - pslverr SHALL be a registered output.
  - It SHALL be 1 during the ACCESS cycle of a write whose paddr is ID or WCNT, and 0 otherwise.
REQ-020 Without APB_REGFILE_PSLVERR_EN:
  - port pslverr and its logic SHALL be absent.
  - Writes to read-only addresses SHALL be silently ignored, per REQ-010.

Structure
REQ-021 Package apb_regfile_pkg SHALL hold:
  - phase state typedef (IDLE/SETUP/ACCESS)
  - ID_ADDR and WCNT_ADDR offset constants
REQ-022 The phase FSM and protocol checking SHALL be sub-module apb_phase_fsm.
  - Inputs: psel, penable.
  - Outputs: state, setup_fire, access_fire, proto_viol.
REQ-023 The register array and WCNT SHALL live in apb_regfile_slave.

Verification
REQ-024 Write addr 3 = 8'h5C, then read addr 3 -> prdata = 8'h5C, stable one cycle after ACCESS; WCNT reads 1.
REQ-025 Read addr 0 after reset -> 8'hA5; write addr 0 = 8'h00 -> addr 0 still 8'hA5, WCNT increments, pslverr=1 in ACCESS (macro on only).
REQ-026 256 writes to addr 1 -> WCNT reads 8'h00 (wrap); 257th write -> 8'h01.
REQ-027 psel=1 with penable=1 from IDLE -> proto_err=1 next cycle, addr 1 unchanged, flag held until presetn low.
REQ-028 presetn pulsed low while in ACCESS of a write to addr 2 = 8'hFF -> addr 2 reads 8'h00, WCNT 0, FSM IDLE.
REQ-029 Back-to-back write addr 4 = 8'h11, then read addr 4 with no IDLE cycle -> prdata = 8'h11, no proto_err.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared phase type and register-map constants for the APB register-file slave.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_t;

    localparam int ID_ADDR   = 0;
    // WCNT sits at the top of the map: this offset is added to 2**AWIDTH.
    localparam int WCNT_ADDR = -1;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// APB bus bundle for the register-file slave.
// pslverr is only present when APB_REGFILE_PSLVERR_EN is defined.
interface apb_regfile_slave_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              proto_err;

`ifdef APB_REGFILE_PSLVERR_EN
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, proto_err, pslverr
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, proto_err, pslverr
    );
`else
    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, proto_err
    );
    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, proto_err
    );
`endif

endinterface

// File: rtl/apb_phase_fsm.sv
// APB phase tracker with protocol checking; the registered state lags the
// bus by one cycle, so SETUP here means the bus is in its access cycle.
//
//   state  | meaning
//   IDLE   | no transfer in progress; waiting for psel & !penable
//   SETUP  | setup phase sampled; bus is now in its access cycle
//   ACCESS | access phase sampled; transfer done, back-to-back setup allowed
module apb_phase_fsm
    import apb_regfile_pkg::*;
(
    input  logic   pclk,
    input  logic   presetn,
    input  logic   psel,
    input  logic   penable,
    output phase_t state,
    output logic   setup_fire,
    output logic   access_fire,
    output logic   proto_viol
);

    always_comb begin
        setup_fire  = psel && !penable && (state != SETUP);
        access_fire = psel && penable && (state == SETUP);
        proto_viol  = ((state == IDLE) && penable) ||
                      ((state == SETUP) && psel && !penable);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= (psel && !penable) ? SETUP : IDLE;
                // A repeated setup restarts the transfer rather than dropping it.
                SETUP:   if (psel && penable)       state <= ACCESS;
                         else if (psel && !penable) state <= SETUP;
                         else                       state <= IDLE;
                ACCESS:  state <= (psel && !penable) ? SETUP : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// Zero-wait-state APB register file with read-only ID and write counter.
// Define APB_REGFILE_PSLVERR_EN to add pslverr on writes to read-only addresses.
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int                AWIDTH = 4,
    parameter int                DWIDTH = 8,
    parameter logic [DWIDTH-1:0] ID_VAL = 8'hA5
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_regfile_slave_if.slave  bus
);

    localparam int                NREG   = 2**AWIDTH;
    localparam logic [AWIDTH-1:0] ID_A   = AWIDTH'(ID_ADDR);
    localparam logic [AWIDTH-1:0] WCNT_A = AWIDTH'(NREG + WCNT_ADDR);

    phase_t            state;
    logic              setup_fire;
    logic              access_fire;
    logic              proto_viol;

    logic [DWIDTH-1:0] regs [NREG];
    logic [DWIDTH-1:0] wcnt;
    logic [DWIDTH-1:0] prdata_q;
    logic [DWIDTH-1:0] rd_data;
    logic              proto_err_q;
    logic              addr_ro;
    logic              wr_commit;

    apb_phase_fsm u_fsm (
        .pclk        (pclk),
        .presetn     (presetn),
        .psel        (bus.psel),
        .penable     (bus.penable),
        .state       (state),
        .setup_fire  (setup_fire),
        .access_fire (access_fire),
        .proto_viol  (proto_viol)
    );

    always_comb begin
        addr_ro   = (bus.paddr == ID_A) || (bus.paddr == WCNT_A);
        wr_commit = access_fire && bus.pwrite && (state == SETUP);
        if (bus.paddr == ID_A)
            rd_data = ID_VAL;
        else if (bus.paddr == WCNT_A)
            rd_data = wcnt;
        else
            rd_data = regs[bus.paddr];
    end

    // prdata only reloads on a read setup, so it holds after the access cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            wcnt        <= '0;
            prdata_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (wr_commit) begin
                wcnt <= wcnt + DWIDTH'(1);
                if (!addr_ro) regs[bus.paddr] <= bus.pwdata;
            end
            if (setup_fire && !bus.pwrite) prdata_q <= rd_data;
            if (proto_viol) proto_err_q <= 1'b1;
        end
    end

    assign bus.prdata    = prdata_q;
    assign bus.proto_err = proto_err_q;

`ifdef APB_REGFILE_PSLVERR_EN
    logic pslverr_q;

    // Set from the setup edge so the flag is valid across the bus access cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) pslverr_q <= 1'b0;
        else          pslverr_q <= setup_fire && bus.pwrite && addr_ro;
    end

    assign bus.pslverr = pslverr_q;
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Scoreboard bench for apb_regfile_slave: read expectations are queued at
// setup from a register model and compared during the access cycle.
module tb_apb_regfile_slave;
    import apb_regfile_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic pclk    = 1'b0;
    logic presetn = 1'b1;

    apb_regfile_slave_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    apb_regfile_slave #(.AWIDTH(AW), .DWIDTH(DW), .ID_VAL(8'hA5)) u_dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  mdl [16];
    logic [7:0]  mdl_wcnt;
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        foreach (mdl[i]) mdl[i] = 8'h00;
        mdl_wcnt = 8'h00;
        exp_q.delete();
    endtask

    function automatic logic [7:0] mdl_rd(input int a);
        if (a == 0)  return 8'hA5;
        if (a == 15) return mdl_wcnt;
        return mdl[a];
    endfunction

    task automatic mdl_wr(input int a, input logic [7:0] d);
        if (a != 0 && a != 15) mdl[a] = d;
        mdl_wcnt = mdl_wcnt + 8'd1;
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(posedge pclk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        presetn     = 1'b0;
        #3;
        presetn     = 1'b1;
        mdl_reset();
    endtask

    task automatic apb_write(input int a, input logic [7:0] d);
        @(posedge pclk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 4'(a);
        bus.pwdata  = d;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
`ifdef APB_REGFILE_PSLVERR_EN
        @(negedge pclk);
        chk("pslverr", 32'(bus.pslverr), 32'(a == 0 || a == 15));
`endif
        mdl_wr(a, d);
    endtask

    task automatic apb_read(input int a);
        @(posedge pclk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 4'(a);
        exp_q.push_back(mdl_rd(a));
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        if (exp_q.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
        else chk($sformatf("rd_addr%0d", a), 32'(bus.prdata), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        mdl_reset();

        #1 presetn = 1'b0;
        #1;
        chk("rst_prdata",    32'(bus.prdata),    32'h0);
        chk("rst_proto_err", 32'(bus.proto_err), 32'h0);
        chk("rst_fsm",       32'(u_dut.u_fsm.state), 32'(IDLE));
`ifdef APB_REGFILE_PSLVERR_EN
        chk("rst_pslverr",   32'(bus.pslverr),   32'h0);
`endif
        #10 presetn = 1'b1;

        // ID and counter after reset
        apb_read(0);
        apb_read(15);
        bus_idle(1);

        // basic write/read with hold after access
        apb_write(3, 8'h5C);
        bus_idle(1);
        apb_read(3);
        bus_idle(1);
        @(negedge pclk);
        chk("rd_hold", 32'(bus.prdata), 32'h5C);
        apb_read(15);
        bus_idle(1);

        // write to read-only ID
        apb_write(0, 8'h00);
        bus_idle(1);
        apb_read(0);
        apb_read(15);
        bus_idle(1);

        // back-to-back write then read
        apb_write(4, 8'h11);
        apb_read(4);
        chk("b2b_proto_err", 32'(bus.proto_err), 32'h0);
        bus_idle(1);

        // random traffic over the RW range
        for (int k = 0; k < 8; k++) begin
            int         a;
            logic [7:0] d;
            a = int'($urandom_range(1, 14));
            d = 8'($urandom_range(0, 255));
            apb_write(a, d);
            apb_read(a);
        end
        apb_read(15);
        bus_idle(1);

        // counter wrap
        apply_reset();
        for (int k = 0; k < 256; k++) apb_write(1, 8'(k));
        bus_idle(1);
        apb_read(15);
        apb_read(1);
        apb_write(1, 8'h42);
        apb_read(15);
        bus_idle(1);

        // penable from IDLE is a violation with no write
        @(posedge pclk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = 4'd1;
        bus.pwdata  = 8'hFF;
        @(posedge pclk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        chk("idle_proto_err", 32'(bus.proto_err), 32'h1);
        apb_read(1);
        apb_read(15);
        bus_idle(3);
        @(negedge pclk);
        chk("proto_err_sticky", 32'(bus.proto_err), 32'h1);
        apply_reset();
        @(negedge pclk);
        chk("proto_err_cleared", 32'(bus.proto_err), 32'h0);

        // repeated setup is a violation but the transfer still completes
        @(posedge pclk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 4'd5;
        bus.pwdata  = 8'h33;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        mdl_wr(5, 8'h33);
        @(negedge pclk);
        chk("setup_proto_err", 32'(bus.proto_err), 32'h1);
        bus_idle(1);
        apb_read(5);
        apb_read(15);
        bus_idle(1);

        // reset during the access cycle aborts the write
        apply_reset();
        apb_write(2, 8'h77);
        bus_idle(1);
        apb_read(2);
        bus_idle(1);
        @(posedge pclk); #1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = 4'd2;
        bus.pwdata  = 8'hFF;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #2 presetn  = 1'b0;
        #1;
        chk("midrst_fsm",    32'(u_dut.u_fsm.state), 32'(IDLE));
        chk("midrst_prdata", 32'(bus.prdata), 32'h0);
        #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        presetn     = 1'b1;
        mdl_reset();
        apb_read(2);
        apb_read(15);
        bus_idle(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
